mul_div_unit: RTL

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative 32-bit multiply/divide unit. It takes one operation at a time.
//
// Ports
//   clk          : clock, rising edge active
//   reset_n      : asynchronous active-low reset
//   flush        : synchronous abort of any in-flight or pending operation
//   req_valid    : a request is present
//   req_ready    : high when the unit can accept a request
//   req_op       : 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//                  100 DIV, 101 DIVU, 110 REM,    111 REMU
//   req_a        : multiplicand / dividend
//   req_b        : multiplier / divisor
//   resp_valid   : a result is present
//   resp_ready   : the consumer accepts the result
//   resp_result  : result of the operation
//
// state | meaning
// IDLE  | waiting for a request
// BUSY  | 32 shift-add / shift-subtract iterations on operand magnitudes
// FIX   | apply sign correction and select the result
// DONE  | result presented until resp_ready
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_result
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [5:0]       r_cnt;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_hi, r_lo, r_opnd, r_result;
  logic             r_neg_q, r_neg_r;

  logic             w_accept, w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_mag_a, w_mag_b;
  logic             w_div0, w_ovf, w_bypass;
  logic [WIDTH-1:0] w_bypass_res;
  logic [WIDTH:0]   w_mul_sum, w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [2*WIDTH-1:0] w_prod, w_prod_s;
  logic [WIDTH-1:0] w_quo_s, w_rem_s, w_fix_res;

  assign req_ready   = (r_state == S_IDLE) & ~flush;
  assign resp_valid  = (r_state == S_DONE);
  assign resp_result = r_result;
  assign w_accept    = req_valid & req_ready;

  // Operand signedness and magnitude conversion at acceptance.
  assign w_a_signed = (req_op == 3'b001) | (req_op == 3'b010) |
                      (req_op == 3'b100) | (req_op == 3'b110);
  assign w_b_signed = (req_op == 3'b001) | (req_op == 3'b100) | (req_op == 3'b110);
  assign w_a_neg    = w_a_signed & req_a[WIDTH-1];
  assign w_b_neg    = w_b_signed & req_b[WIDTH-1];
  assign w_mag_a    = w_a_neg ? -req_a : req_a;
  assign w_mag_b    = w_b_neg ? -req_b : req_b;

  // Divide-by-zero and signed overflow skip the iterative path.
  assign w_div0   = req_op[2] & (req_b == '0);
  assign w_ovf    = ((req_op == 3'b100) | (req_op == 3'b110)) &
                    (req_a == MIN_NEG) & (req_b == '1);
  assign w_bypass = w_div0 | w_ovf;
  always_comb begin
    w_bypass_res = '0;
    if (w_div0)
      w_bypass_res = req_op[1] ? req_a : '1;
    else
      w_bypass_res = req_op[1] ? '0 : MIN_NEG;
  end

  // Multiply step: r_lo holds the multiplier and shifts right while the product builds in r_hi.
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);

  // Restoring divide step: r_lo holds the dividend and is shifted out as quotient bits shift in.
  // The remainder is always below the divisor, so the subtraction fits in WIDTH bits.
  assign w_shift   = {r_hi, r_lo[WIDTH-1]};
  assign w_ge      = (w_shift >= {1'b0, r_opnd});
  assign w_rem_nxt = w_ge ? (w_shift[WIDTH-1:0] - r_opnd) : w_shift[WIDTH-1:0];

  assign w_prod   = {r_hi, r_lo};
  assign w_prod_s = r_neg_q ? -w_prod : w_prod;
  assign w_quo_s  = r_neg_q ? -r_lo : r_lo;
  assign w_rem_s  = r_neg_r ? -r_hi : r_hi;

  always_comb begin
    w_fix_res = '0;
    case (r_op)
      3'b000:                 w_fix_res = w_prod_s[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: w_fix_res = w_prod_s[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         w_fix_res = w_quo_s;
      default:                w_fix_res = w_rem_s;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = w_bypass ? S_DONE : S_BUSY;
      S_BUSY: if (r_cnt == 6'd31) w_state_nxt = S_FIX;
      S_FIX:  w_state_nxt = S_DONE;
      S_DONE: if (resp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_opnd   <= '0;
      r_result <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else if (flush) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_op    <= req_op;
      r_cnt   <= '0;
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
      r_hi    <= '0;
      r_lo    <= req_op[2] ? w_mag_a : w_mag_b;
      r_opnd  <= req_op[2] ? w_mag_b : w_mag_a;
      if (w_bypass) r_result <= w_bypass_res;
    end else if (r_state == S_BUSY) begin
      r_cnt <= r_cnt + 6'd1;
      if (r_op[2]) begin
        r_hi <= w_rem_nxt;
        r_lo <= {r_lo[WIDTH-2:0], w_ge};
      end else begin
        {r_hi, r_lo} <= {w_mul_sum, r_lo[WIDTH-1:1]};
      end
    end else if (r_state == S_FIX) begin
      r_result <= w_fix_res;
    end
  end

endmodule
